// File: rtl/alu_sched_pkg.sv
// alu_sched_pkg: FSM states, blank segment pattern and hex-to-7-segment table for alu_seg_scheduler.
package alu_sched_pkg;
    typedef enum logic {IDLE, EXEC} state_t;
    localparam logic [6:0] SEG_BLANK = 7'b0;
    // Entry v is the {a,b,c,d,e,f,g} pattern for hex digit v.
    localparam logic [15:0][6:0] HEX7 = {
        7'b1000111, 7'b1001111, 7'b0111101, 7'b1001110,
        7'b0011111, 7'b1110111, 7'b1111011, 7'b1111111,
        7'b1110000, 7'b1011111, 7'b1011011, 7'b0110011,
        7'b1111001, 7'b1101101, 7'b0110000, 7'b1111110
    };
endpackage

// File: rtl/seg7_hex_decode.sv
// seg7_hex_decode: combinational N-bit value to active-high 7-segment pattern {a,b,c,d,e,f,g}.
module seg7_hex_decode
    import alu_sched_pkg::*;
#(
    parameter int N = 4
) (
    input  logic [N-1:0] val_i,
    output logic [6:0]   seg_o
);
    assign seg_o = HEX7[val_i];
endmodule

// File: rtl/alu_seg_scheduler.sv
// alu_seg_scheduler: arbitrates NREQ requesters onto one external ALU and scans their results onto a 7-segment display.
// ALU_SCHED_FIXED_PRIO_EN selects fixed lowest-index priority instead of round-robin.
module alu_seg_scheduler
    import alu_sched_pkg::*;
#(
    parameter int N        = 4,
    parameter int NREQ     = 4,
    parameter int SCAN_DIV = 1000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   req_valid,
    output logic [NREQ-1:0]   req_ready,
    input  logic [NREQ*N-1:0] req_a,
    input  logic [NREQ*N-1:0] req_b,
    input  logic [NREQ*2-1:0] req_op,
    output logic [N-1:0]      alu_a,
    output logic [N-1:0]      alu_b,
    output logic [1:0]        alu_op,
    input  logic [N-1:0]      alu_y,
    input  logic              enable,
    output logic [6:0]        seg,
    output logic [NREQ-1:0]   dig_en,
    output logic              busy
);
    localparam int IW = $clog2(NREQ);
    localparam int CW = $clog2(SCAN_DIV);
    localparam logic [NREQ-1:0] ONE = NREQ'(1);

    state_t                   state_q;
    logic [IW-1:0]            cur_q;
    logic [IW-1:0]            win;
    logic                     any_v;
    logic [N-1:0]             alu_a_q;
    logic [N-1:0]             alu_b_q;
    logic [1:0]               alu_op_q;
    logic [NREQ-1:0][N-1:0]   res_q;
    logic [NREQ-1:0]          written_q;
    logic [CW-1:0]            scan_q;
    logic [IW-1:0]            digit_q;
    logic [6:0]               seg_q;
    logic [6:0]               dec;
    logic [NREQ-1:0]          dig_en_q;

`ifdef ALU_SCHED_FIXED_PRIO_EN
    always_comb begin
        win   = '0;
        any_v = 1'b0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (req_valid[i]) begin
                win   = IW'(i);
                any_v = 1'b1;
            end
        end
    end
`else
    logic [IW-1:0] last_q;
    int            k;

    // Walk from farthest to nearest so the index right after last_q wins.
    always_comb begin
        win   = '0;
        any_v = 1'b0;
        k     = 0;
        for (int i = NREQ; i >= 1; i--) begin
            k = (int'(last_q) + i) % NREQ;
            if (req_valid[k]) begin
                win   = IW'(k);
                any_v = 1'b1;
            end
        end
    end
`endif

    assign req_ready = (!rst && state_q == IDLE && any_v) ? ONE << win : '0;
    assign busy      = (state_q == EXEC);
    assign alu_a     = alu_a_q;
    assign alu_b     = alu_b_q;
    assign alu_op    = alu_op_q;
    assign seg       = seg_q;
    assign dig_en    = dig_en_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            cur_q     <= '0;
            alu_a_q   <= '0;
            alu_b_q   <= '0;
            alu_op_q  <= '0;
            res_q     <= '0;
            written_q <= '0;
`ifndef ALU_SCHED_FIXED_PRIO_EN
            last_q    <= IW'(NREQ - 1);
`endif
        end else if (state_q == IDLE) begin
            if (any_v) begin
                alu_a_q  <= req_a[win*N +: N];
                alu_b_q  <= req_b[win*N +: N];
                alu_op_q <= req_op[win*2 +: 2];
                cur_q    <= win;
`ifndef ALU_SCHED_FIXED_PRIO_EN
                last_q   <= win;
`endif
                state_q  <= EXEC;
            end
        end else begin
            res_q[cur_q]     <= alu_y;
            written_q[cur_q] <= 1'b1;
            state_q          <= IDLE;
        end
    end

    seg7_hex_decode #(.N(N)) u_dec (
        .val_i (res_q[digit_q]),
        .seg_o (dec)
    );

    // Display registers read res_q before any same-cycle capture lands.
    always_ff @(posedge clk) begin
        if (rst || !enable) begin
            scan_q   <= '0;
            digit_q  <= '0;
            seg_q    <= SEG_BLANK;
            dig_en_q <= '0;
        end else begin
            scan_q   <= (scan_q == CW'(SCAN_DIV - 1)) ? '0 : scan_q + CW'(1);
            if (scan_q == CW'(SCAN_DIV - 1))
                digit_q <= (digit_q == IW'(NREQ - 1)) ? '0 : digit_q + IW'(1);
            dig_en_q <= ONE << digit_q;
            seg_q    <= written_q[digit_q] ? dec : SEG_BLANK;
        end
    end
endmodule

// File: tb/tb_alu_seg_scheduler.sv
// tb_alu_seg_scheduler: directed self-checking bench for alu_seg_scheduler with NREQ=4, SCAN_DIV=4.
module tb_alu_seg_scheduler;
    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req_valid;
    logic [3:0]  req_ready;
    logic [15:0] req_a;
    logic [15:0] req_b;
    logic [7:0]  req_op;
    logic [3:0]  alu_a;
    logic [3:0]  alu_b;
    logic [1:0]  alu_op;
    logic [3:0]  alu_y;
    logic        enable;
    logic [6:0]  seg;
    logic [3:0]  dig_en;
    logic        busy;
    int          vectors = 0;
    int          miscompares = 0;

    always #5 clk = ~clk;

    // External ALU: add, sub, and, xor.
    always_comb
        alu_y = (alu_op == 2'd0) ? alu_a + alu_b :
                (alu_op == 2'd1) ? alu_a - alu_b :
                (alu_op == 2'd2) ? (alu_a & alu_b) : (alu_a ^ alu_b);

    alu_seg_scheduler #(.N(4), .NREQ(4), .SCAN_DIV(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_op    (req_op),
        .alu_a     (alu_a),
        .alu_b     (alu_b),
        .alu_op    (alu_op),
        .alu_y     (alu_y),
        .enable    (enable),
        .seg       (seg),
        .dig_en    (dig_en),
        .busy      (busy)
    );

    task automatic set_req(input int k, input logic [3:0] a, input logic [3:0] b, input logic [1:0] op);
        req_a[k*4 +: 4]  = a;
        req_b[k*4 +: 4]  = b;
        req_op[k*2 +: 2] = op;
    endtask

    task automatic test_reset();
        rst = 1'b1; enable = 1'b0; req_valid = 4'b1111;
        req_a = '0; req_b = '0; req_op = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        vectors++; if (req_ready !== 4'b0000) begin miscompares++; $display("FAIL reset_ready got %b exp 0000", req_ready); end
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy got %b exp 0", busy); end
        vectors++; if ({alu_a, alu_b, alu_op} !== 10'd0) begin miscompares++; $display("FAIL reset_alu got %h/%h/%h exp 0/0/0", alu_a, alu_b, alu_op); end
        vectors++; if (seg !== 7'b0) begin miscompares++; $display("FAIL reset_seg got %b exp 0000000", seg); end
        vectors++; if (dig_en !== 4'b0000) begin miscompares++; $display("FAIL reset_dig_en got %b exp 0000", dig_en); end
        req_valid = 4'b0000;
        @(posedge clk); #1 rst = 1'b0;
    endtask

    task automatic test_reset_mid_exec();
        set_req(1, 4'd3, 4'd4, 2'd0);
        req_valid = 4'b0010;
        @(negedge clk);
        vectors++; if (req_ready !== 4'b0010) begin miscompares++; $display("FAIL midexec_grant got %b exp 0010", req_ready); end
        @(posedge clk); #1 req_valid = 4'b0000; rst = 1'b1;
        @(negedge clk);
        vectors++; if (req_ready !== 4'b0000) begin miscompares++; $display("FAIL midexec_ready_in_rst got %b exp 0000", req_ready); end
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL midexec_busy got %b exp 0", busy); end
        vectors++; if ({alu_a, alu_b} !== 8'h00) begin miscompares++; $display("FAIL midexec_alu got %h/%h exp 0/0", alu_a, alu_b); end
        @(posedge clk); #1;
    endtask

    task automatic test_single();
        set_req(2, 4'd9, 4'd6, 2'd0);
        req_valid = 4'b0100;
        @(negedge clk);
        vectors++; if (req_ready !== 4'b0100) begin miscompares++; $display("FAIL single_ready got %b exp 0100", req_ready); end
        @(posedge clk); #1 req_valid = 4'b0000;
        @(negedge clk);
        vectors++; if ({alu_a, alu_b, alu_op} !== {4'd9, 4'd6, 2'd0}) begin miscompares++; $display("FAIL single_alu got %h/%h/%h exp 9/6/0", alu_a, alu_b, alu_op); end
        vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL single_busy got %b exp 1", busy); end
        vectors++; if (req_ready !== 4'b0000) begin miscompares++; $display("FAIL single_ready_exec got %b exp 0000", req_ready); end
        vectors++; if (dig_en !== 4'b0000) begin miscompares++; $display("FAIL single_dig_en_disabled got %b exp 0000", dig_en); end
        @(posedge clk); #1;
        @(negedge clk);
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL single_busy_done got %b exp 0", busy); end
        @(posedge clk); #1;
    endtask

    task automatic test_scan();
        logic [3:0] exp_dig;
        logic [6:0] exp_seg;
        enable = 1'b1;
        @(negedge clk);
        vectors++; if (dig_en !== 4'b0000) begin miscompares++; $display("FAIL scan_pre_enable got %b exp 0000", dig_en); end
        for (int i = 0; i <= 16; i++) begin
            @(posedge clk);
            @(negedge clk);
            exp_dig = 4'b0001 << ((i / 4) % 4);
            exp_seg = (exp_dig == 4'b0100) ? 7'b1000111 : 7'b0000000;
            vectors++; if (dig_en !== exp_dig) begin miscompares++; $display("FAIL scan_dig_en[%0d] got %b exp %b", i, dig_en, exp_dig); end
            vectors++; if (seg !== exp_seg) begin miscompares++; $display("FAIL scan_seg[%0d] got %b exp %b", i, seg, exp_seg); end
        end
        @(posedge clk); #1;
    endtask

    task automatic test_blanking();
        int n;
        enable = 1'b0;
        set_req(3, 4'd0, 4'd0, 2'd0);
        req_valid = 4'b1000;
        @(negedge clk);
        vectors++; if (req_ready !== 4'b1000) begin miscompares++; $display("FAIL blank_grant got %b exp 1000", req_ready); end
        @(posedge clk); #1 req_valid = 4'b0000;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (i == 0) begin
                vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL blank_busy got %b exp 1", busy); end
            end
            vectors++; if ({seg, dig_en} !== 11'd0) begin miscompares++; $display("FAIL blank_out[%0d] got %b/%b exp 0/0", i, seg, dig_en); end
            @(posedge clk);
        end
        #1 enable = 1'b1;
        @(negedge clk);
        vectors++; if (dig_en !== 4'b0000) begin miscompares++; $display("FAIL blank_enable_same got %b exp 0000", dig_en); end
        @(posedge clk);
        @(negedge clk);
        vectors++; if (dig_en !== 4'b0001) begin miscompares++; $display("FAIL blank_enable_next got %b exp 0001", dig_en); end
        n = 0;
        while (dig_en !== 4'b1000 && n < 20) begin
            @(negedge clk);
            n++;
        end
        vectors++; if (dig_en !== 4'b1000) begin miscompares++; $display("FAIL blank_reach_digit3 got %b exp 1000", dig_en); end
        vectors++; if (seg !== 7'b1111110) begin miscompares++; $display("FAIL blank_res_zero_seg got %b exp 1111110", seg); end
        @(posedge clk); #1;
    endtask

    task automatic test_contention();
        int g;
        for (int k = 0; k < 4; k++) set_req(k, 4'(k + 1), 4'(15 - k), 2'(k));
        req_valid = 4'b1111;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
`ifdef ALU_SCHED_FIXED_PRIO_EN
            g = 0;
`else
            g = (i / 2) % 4;
`endif
            if (i % 2 == 0) begin
                vectors++; if (req_ready !== 4'(1 << g)) begin miscompares++; $display("FAIL contend_grant[%0d] got %b exp %b", i, req_ready, 4'(1 << g)); end
            end else begin
                vectors++; if (req_ready !== 4'b0000) begin miscompares++; $display("FAIL contend_exec_ready[%0d] got %b exp 0000", i, req_ready); end
                vectors++; if ({alu_a, alu_op} !== {4'(g + 1), 2'(g)}) begin miscompares++; $display("FAIL contend_alu[%0d] got %h/%h exp %h/%h", i, alu_a, alu_op, g + 1, g); end
            end
            @(posedge clk); #1;
        end
        req_valid = 4'b0000;
        @(posedge clk); #1;
    endtask

    task automatic test_drop();
        req_valid = 4'b0110;
        @(negedge clk);
        vectors++; if (req_ready !== 4'b0010) begin miscompares++; $display("FAIL drop_offer got %b exp 0010", req_ready); end
        req_valid = 4'b0100;
        #1;
        vectors++; if (req_ready !== 4'b0100) begin miscompares++; $display("FAIL drop_reoffer got %b exp 0100", req_ready); end
        @(posedge clk); #1 req_valid = 4'b0000;
        @(negedge clk);
        vectors++; if (alu_a !== 4'd3) begin miscompares++; $display("FAIL drop_alu_a got %h exp 3", alu_a); end
        @(posedge clk); #1;
    endtask

    initial begin
        test_reset();
        test_reset_mid_exec();
        test_single();
        test_scan();
        test_blanking();
        test_contention();
        test_drop();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog got timeout exp completion");
        $fatal(1, "watchdog");
    end
endmodule
